// File: rtl/red_pitaya_iq_filter_cascade.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : red_pitaya_iq_filter_cascade
// Purpose  : Cascade of STAGES first-order IIR sections on the IQ demodulator
//            output path. Each section can run as low-pass, high-pass or
//            bypass. Coefficients and modes are taken atomically from the
//            alpha_i/mode_i inputs on a cfg_load_i strobe. Per-stage sticky
//            saturation flags report clipping.
//
// Ports    : clk_i       system clock
//            rstn_i      synchronous reset, active-low
//            alpha_i     signed alphas, stage k at [k*HIGHESTALPHABIT +: HIGHESTALPHABIT]
//            mode_i      stage k at [2k +: 2]: 00/11 bypass, 01 LPF, 10 HPF
//            cfg_load_i  one-cycle strobe: load alpha_i/mode_i as active
//            sat_clr_i   clear all sticky saturation flags
//            signal_i    signed input sample, one per clock
//            signal_o    signed filtered output (latency STAGES cycles)
//            sat_o       sticky saturation flag per stage
//
// Option   : `define IQ_FILTER_CASCADE_ROUND_EN for round-half-up LPF output
//            (with saturation on rounding overflow); default is truncation.
//
// Revision : 1.0  initial release
// ============================================================================
module red_pitaya_iq_filter_cascade #(
    parameter int STAGES          = 2,
    parameter int ALPHABITS       = 25,
    parameter int HIGHESTALPHABIT = 18,
    parameter int SIGBITS         = 14
) (
    input  logic                                clk_i,
    input  logic                                rstn_i,
    input  logic [STAGES*HIGHESTALPHABIT-1:0]   alpha_i,
    input  logic [2*STAGES-1:0]                 mode_i,
    input  logic                                cfg_load_i,
    input  logic                                sat_clr_i,
    input  logic signed [SIGBITS-1:0]           signal_i,
    output logic signed [SIGBITS-1:0]           signal_o,
    output logic [STAGES-1:0]                   sat_o
);

    // Accumulator, difference and product widths.
    localparam int c_YW = SIGBITS + ALPHABITS;
    localparam int c_DW = SIGBITS + 1;
    localparam int c_PW = c_DW + HIGHESTALPHABIT;

    localparam logic [1:0] c_MODE_LPF = 2'b01;
    localparam logic [1:0] c_MODE_HPF = 2'b10;

    localparam logic signed [SIGBITS-1:0] c_SAT_POS = {1'b0, {(SIGBITS-1){1'b1}}};
    localparam logic signed [SIGBITS-1:0] c_SAT_NEG = {1'b1, {(SIGBITS-1){1'b0}}};

    // Registered stage outputs and flags, packed so each stage drives only
    // its own slice.
    logic [STAGES*SIGBITS-1:0] w_out_bus;
    logic [STAGES-1:0]         w_sat_bus;

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            logic signed [SIGBITS-1:0]         w_x;
            logic signed [SIGBITS-1:0]         w_yout;
            logic signed [c_DW-1:0]            w_diff;
            logic signed [c_PW-1:0]            w_prod;
            logic signed [SIGBITS-1:0]         w_hpf;
            logic                              w_hpf_clip;
            logic signed [SIGBITS-1:0]         w_lpf;
            logic                              w_lpf_clip;
            logic signed [SIGBITS-1:0]         w_out_nxt;
            logic                              w_sat_evt;
            logic [1:0]                        w_mode_new;
            logic                              w_mode_chg;

            logic signed [c_YW-1:0]            r_y;
            logic signed [c_PW-1:0]            r_delta;
            logic signed [HIGHESTALPHABIT-1:0] r_alpha;
            logic [1:0]                        r_mode;
            logic signed [SIGBITS-1:0]         r_out;
            logic                              r_sat;

            if (k == 0) begin : g_in_first
                assign w_x = signal_i;
            end else begin : g_in_chain
                assign w_x = w_out_bus[(k-1)*SIGBITS +: SIGBITS];
            end

            assign w_yout = r_y[c_YW-1:ALPHABITS];
            // One extra bit so x - y_out can never wrap.
            assign w_diff = {w_x[SIGBITS-1], w_x} - {w_yout[SIGBITS-1], w_yout};
            assign w_prod = w_diff * r_alpha;

            // HPF output: clip diff to SIGBITS when its top two bits disagree.
            always_comb begin
                w_hpf      = w_diff[SIGBITS-1:0];
                w_hpf_clip = 1'b0;
                if (w_diff[SIGBITS:SIGBITS-1] == 2'b01) begin
                    w_hpf      = c_SAT_POS;
                    w_hpf_clip = 1'b1;
                end else if (w_diff[SIGBITS:SIGBITS-1] == 2'b10) begin
                    w_hpf      = c_SAT_NEG;
                    w_hpf_clip = 1'b1;
                end
            end

`ifdef IQ_FILTER_CASCADE_ROUND_EN
            // Round half-up: adding 2^(ALPHABITS-1) before truncation equals
            // adding the first bit below the output LSB to y_out. Only a
            // positive overflow is possible.
            logic signed [SIGBITS:0] w_lpf_sum;
            assign w_lpf_sum = {w_yout[SIGBITS-1], w_yout}
                             + {{SIGBITS{1'b0}}, r_y[ALPHABITS-1]};
            always_comb begin
                w_lpf      = w_lpf_sum[SIGBITS-1:0];
                w_lpf_clip = 1'b0;
                if (w_lpf_sum[SIGBITS:SIGBITS-1] == 2'b01) begin
                    w_lpf      = c_SAT_POS;
                    w_lpf_clip = 1'b1;
                end
            end
`else
            assign w_lpf      = w_yout;
            assign w_lpf_clip = 1'b0;
`endif

            // Bypass still passes through the output register so the
            // cascade latency is independent of the mode mix.
            always_comb begin
                w_out_nxt = w_x;
                w_sat_evt = 1'b0;
                case (r_mode)
                    c_MODE_LPF: begin
                        w_out_nxt = w_lpf;
                        w_sat_evt = w_lpf_clip;
                    end
                    c_MODE_HPF: begin
                        w_out_nxt = w_hpf;
                        w_sat_evt = w_hpf_clip;
                    end
                    default: ;
                endcase
            end

            assign w_mode_new = mode_i[2*k +: 2];
            assign w_mode_chg = cfg_load_i && (w_mode_new != r_mode);

            always_ff @(posedge clk_i) begin
                if (!rstn_i) begin
                    r_y     <= '0;
                    r_delta <= '0;
                    r_alpha <= '0;
                    r_mode  <= 2'b00;
                    r_out   <= '0;
                    r_sat   <= 1'b0;
                end else begin
                    // A mode switch restarts the section from zero; an
                    // alpha-only load leaves the accumulator untouched.
                    if (w_mode_chg) begin
                        r_y     <= '0;
                        r_delta <= '0;
                    end else begin
                        r_delta <= w_prod;
                        r_y     <= r_y + c_YW'(r_delta);
                    end
                    if (cfg_load_i) begin
                        r_alpha <= alpha_i[k*HIGHESTALPHABIT +: HIGHESTALPHABIT];
                        r_mode  <= w_mode_new;
                    end
                    r_out <= w_out_nxt;
                    // A new clip in the same cycle as a clear wins.
                    r_sat <= (r_sat & ~sat_clr_i) | w_sat_evt;
                end
            end

            assign w_out_bus[k*SIGBITS +: SIGBITS] = r_out;
            assign w_sat_bus[k]                    = r_sat;
        end
    endgenerate

    assign signal_o = w_out_bus[(STAGES-1)*SIGBITS +: SIGBITS];
    assign sat_o    = w_sat_bus;

endmodule
`default_nettype wire

// File: tb/tb_red_pitaya_iq_filter_cascade.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_red_pitaya_iq_filter_cascade
// Purpose  : Self-checking bench for red_pitaya_iq_filter_cascade. A cycle
//            model of the filter arithmetic predicts signal_o/sat_o; the
//            predictions are queued when stimulus is driven and compared when
//            the DUT output is due. A bypass vector table and hand-written
//            sequences cover latency, steps, saturation, config and reset.
// Revision : 1.0  initial release
// ============================================================================
module tb_red_pitaya_iq_filter_cascade;

    localparam int STAGES    = 2;
    localparam int ALPHABITS = 25;
    localparam int HAB       = 18;
    localparam int SIGBITS   = 14;
    localparam int YW        = SIGBITS + ALPHABITS;
    localparam int MAXV      = 8191;
    localparam int MINV      = -8192;
    // Largest positive 18-bit alpha: gain of about 2^-8 per cycle.
    localparam int A17       = 131071;
    localparam int A16       = 65536;

    logic                        clk = 1'b0;
    logic                        rstn_i;
    logic [STAGES*HAB-1:0]       alpha_i;
    logic [2*STAGES-1:0]         mode_i;
    logic                        cfg_load_i;
    logic                        sat_clr_i;
    logic signed [SIGBITS-1:0]   signal_i;
    logic signed [SIGBITS-1:0]   signal_o;
    logic [STAGES-1:0]           sat_o;

    red_pitaya_iq_filter_cascade #(
        .STAGES          (STAGES),
        .ALPHABITS       (ALPHABITS),
        .HIGHESTALPHABIT (HAB),
        .SIGBITS         (SIGBITS)
    ) dut (
        .clk_i      (clk),
        .rstn_i     (rstn_i),
        .alpha_i    (alpha_i),
        .mode_i     (mode_i),
        .cfg_load_i (cfg_load_i),
        .sat_clr_i  (sat_clr_i),
        .signal_i   (signal_i),
        .signal_o   (signal_o),
        .sat_o      (sat_o)
    );

    always #4 clk = ~clk;

    typedef struct {
        int due;
        int out;
        int sat;
        bit chk_sat;
    } sb_t;

    typedef struct {
        int sig;
        int exp;
    } vec_t;

    sb_t    sb_q[$];
    int     n_cmp = 0;
    int     n_err = 0;
    int     cyc   = 0;
    string  phase = "reset";

    // Reference model state
    longint m_y     [STAGES];
    longint m_d     [STAGES];
    int     m_out   [STAGES];
    int     m_alpha [STAGES];
    int     m_mode  [STAGES];
    int     m_sat   [STAGES];

    function automatic longint wrap_y(longint v);
        return (v <<< (64 - YW)) >>> (64 - YW);
    endfunction

    function automatic int sat_pack();
        int s = 0;
        for (int k = 0; k < STAGES; k++) s = s | (m_sat[k] << k);
        return s;
    endfunction

    function automatic logic [STAGES*HAB-1:0] mk_alpha(int a0, int a1);
        return {18'(a1), 18'(a0)};
    endfunction

    function automatic logic [2*STAGES-1:0] mk_mode(int m0, int m1);
        return {2'(m1), 2'(m0)};
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        longint ny [STAGES];
        longint nd [STAGES];
        int     no [STAGES];
        int     ns [STAGES];
        int     na [STAGES];
        int     nm [STAGES];
        for (int k = 0; k < STAGES; k++) begin
            int x, yo, diff, o, ev;
`ifdef IQ_FILTER_CASCADE_ROUND_EN
            longint yr;
`endif
            x    = (k == 0) ? int'(signal_i) : m_out[k-1];
            yo   = int'(m_y[k] >>> ALPHABITS);
            diff = x - yo;
            o    = x;
            ev   = 0;
            if (m_mode[k] == 1) begin
`ifdef IQ_FILTER_CASCADE_ROUND_EN
                yr = (m_y[k] + (64'sd1 <<< (ALPHABITS - 1))) >>> ALPHABITS;
                if (yr > MAXV) begin o = MAXV; ev = 1; end
                else o = int'(yr);
`else
                o = yo;
`endif
            end else if (m_mode[k] == 2) begin
                if (diff > MAXV)      begin o = MAXV; ev = 1; end
                else if (diff < MINV) begin o = MINV; ev = 1; end
                else o = diff;
            end
            nd[k] = longint'(diff) * longint'(m_alpha[k]);
            ny[k] = wrap_y(m_y[k] + m_d[k]);
            na[k] = m_alpha[k];
            nm[k] = m_mode[k];
            if (cfg_load_i) begin
                na[k] = int'($signed(alpha_i[k*HAB +: HAB]));
                nm[k] = int'(mode_i[2*k +: 2]);
                if (nm[k] != m_mode[k]) begin
                    ny[k] = 0;
                    nd[k] = 0;
                end
            end
            ns[k] = (sat_clr_i ? 0 : m_sat[k]) | ev;
            no[k] = o;
            if (!rstn_i) begin
                ny[k] = 0; nd[k] = 0; no[k] = 0; ns[k] = 0; na[k] = 0; nm[k] = 0;
            end
        end
        for (int k = 0; k < STAGES; k++) begin
            m_y[k] = ny[k]; m_d[k] = nd[k]; m_out[k] = no[k];
            m_sat[k] = ns[k]; m_alpha[k] = na[k]; m_mode[k] = nm[k];
        end
    endtask

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_range(string name, int act, int lo, int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
        end
    endtask

    // One clock: step the model, optionally queue its prediction, then
    // compare every queued entry that has come due.
    task automatic tick(bit chk);
        sb_t e;
        model_step();
        if (chk) sb_q.push_back('{due: cyc + 1, out: m_out[STAGES-1], sat: sat_pack(), chk_sat: 1'b1});
        @(posedge clk);
        cyc++;
        #1;
        while (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
            e = sb_q.pop_front();
            check({phase, "_out"}, int'(signal_o), e.out);
            if (e.chk_sat) check({phase, "_sat"}, int'(sat_o), e.sat);
        end
    endtask

    task automatic run(int n, bit chk);
        for (int i = 0; i < n; i++) tick(chk);
    endtask

    task automatic load(int a0, int a1, int m0, int m1);
        alpha_i    = mk_alpha(a0, a1);
        mode_i     = mk_mode(m0, m1);
        cfg_load_i = 1'b1;
        tick(1);
        cfg_load_i = 1'b0;
    endtask

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{sig: 0,     exp: 0};
        vecs[1]  = '{sig: 0,     exp: 0};
        vecs[2]  = '{sig: 1234,  exp: 1234};
        vecs[3]  = '{sig: 0,     exp: 0};
        vecs[4]  = '{sig: 0,     exp: 0};
        vecs[5]  = '{sig: 8191,  exp: 8191};
        vecs[6]  = '{sig: -8192, exp: -8192};
        vecs[7]  = '{sig: -1,    exp: -1};
        vecs[8]  = '{sig: 1,     exp: 1};
        vecs[9]  = '{sig: -4321, exp: -4321};
        vecs[10] = '{sig: 0,     exp: 0};
        vecs[11] = '{sig: 0,     exp: 0};

        rstn_i     = 1'b0;
        alpha_i    = '0;
        mode_i     = '0;
        cfg_load_i = 1'b0;
        sat_clr_i  = 1'b0;
        signal_i   = '0;

        // Reset state
        phase = "reset";
        run(2, 1'b1);
        check("reset_signal_o", int'(signal_o), 0);
        check("reset_sat_o", int'(sat_o), 0);
        rstn_i = 1'b1;

        // Bypass latency from the vector table
        phase = "bypass";
        load(0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            signal_i = 14'(vecs[i].sig);
            sb_q.push_back('{due: cyc + STAGES, out: vecs[i].exp, sat: 0, chk_sat: 1'b0});
            tick(0);
        end
        signal_i = '0;
        run(STAGES, 1'b0);

        // HPF step response
        phase = "hpf_step";
        load(A17, 0, 2, 0);
        run(4, 1'b1);
        signal_i = 14'sd4000;
        tick(1);
        tick(1);
        check("hpf_first", int'(signal_o), 4000);
        tick(1);
        check("hpf_second", int'(signal_o), 4000);
        tick(1);
        check("hpf_third", int'(signal_o), 3985);
        run(256, 1'b1);
        check_range("hpf_tau", int'(signal_o), 1430, 1510);
        run(4740, 1'b0);
        tick(1);
        check_range("hpf_settled", int'(signal_o), -1, 1);
        check("hpf_no_sat", int'(sat_o), 0);

        // LPF step response
        phase = "lpf_step";
        signal_i = '0;
        load(A17, 0, 1, 0);
        run(4, 1'b1);
        signal_i = -14'sd4000;
        run(300, 1'b1);
        run(4700, 1'b0);
        tick(1);
        check_range("lpf_settled", int'(signal_o), -4002, -3998);

        // HPF saturation and sticky flag handling
        phase = "sat";
        signal_i = -14'sd8000;
        load(A17, 0, 2, 0);
        run(10000, 1'b0);
        tick(1);
        signal_i = 14'sd8000;
        tick(1);
        check("sat_set", int'(sat_o), 1);
        tick(1);
        check("sat_first_out", int'(signal_o), 8191);
        run(20, 1'b1);
        run(2000, 1'b0);
        tick(1);
        check("sat_sticky", int'(sat_o), 1);
        sat_clr_i = 1'b1;
        tick(1);
        sat_clr_i = 1'b0;
        check("sat_cleared", int'(sat_o), 0);
        signal_i  = -14'sd8000;
        sat_clr_i = 1'b1;
        tick(1);
        sat_clr_i = 1'b0;
        check("sat_clr_vs_clip", int'(sat_o), 1);
        run(4, 1'b1);

        // Config handshake
        phase = "cfg";
        signal_i = 14'sd3000;
        load(A17, 0, 1, 0);
        run(6000, 1'b0);
        tick(1);
        check("cfg_lpf_settled", int'(signal_o), 3000);
        alpha_i = mk_alpha(A16, 0);
        mode_i  = mk_mode(2, 0);
        run(10, 1'b1);
        check("cfg_no_load", int'(signal_o), 3000);
        load(A16, 0, 1, 0);
        run(10, 1'b1);
        check("cfg_alpha_only", int'(signal_o), 3000);
        load(A16, 0, 2, 0);
        signal_i = 14'sd2500;
        tick(1);
        tick(1);
        check("cfg_mode_clear", int'(signal_o), 2500);

        // Reset during an HPF decay
        phase = "midreset";
        run(50, 1'b1);
        rstn_i = 1'b0;
        tick(1);
        rstn_i = 1'b1;
        check("midreset_out", int'(signal_o), 0);
        check("midreset_sat", int'(sat_o), 0);
        signal_i = 14'sd500;
        tick(1);
        signal_i = '0;
        tick(1);
        check("midreset_bypass", int'(signal_o), 500);
        tick(1);
        check("midreset_after", int'(signal_o), 0);

        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
